// File: rtl/vram_writer_if.sv
// Pixel-stream writer bus: producer handshake, clear control and VRAM write port.
// The master side is the pixel producer / VRAM model, the slave side is vram_writer.
interface vram_writer_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 16
);
    logic              PixValid;
    logic              PixReady;
    logic              PixData;
    logic              PixSof;
    logic              ClearReq;
    logic              ClearVal;
    logic              Busy;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [WORD_W-1:0] WrData;
    logic              FrameDone;

    modport master (
        output PixValid, PixData, PixSof, ClearReq, ClearVal,
        input  PixReady, Busy, WrEn, WrAddr, WrData, FrameDone
    );

    modport slave (
        input  PixValid, PixData, PixSof, ClearReq, ClearVal,
        output PixReady, Busy, WrEn, WrAddr, WrData, FrameDone
    );
endinterface

// File: rtl/vram_writer.sv
// vram_writer: packs a raster-order 1bpp pixel stream into VRAM words and
// writes them with linear word addresses. Optional frame clear engine is
// built when VRAM_WRITER_CLEAR_EN is defined; without it ClearReq/ClearVal
// are ignored and Busy is tied low.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | accepting pixels, one word write per completed word
// ST_CLEAR | filling every word with the latched clear value, one per cycle
module vram_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WORD_W   = 8,
    parameter int ADDR_W   = 16
) (
    input  logic           Clk,
    input  logic           Rst_n,
    vram_writer_if.slave   bus
);

    localparam int N_WORDS = H_ACTIVE * V_ACTIVE / WORD_W;
    localparam int COLS    = H_ACTIVE / WORD_W;
    localparam int BIT_W   = (WORD_W > 1)   ? $clog2(WORD_W)   : 1;
    localparam int COL_W   = (COLS > 1)     ? $clog2(COLS)     : 1;
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_pix_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_frame_done;

    // Pixel position: bit within word, word within row, row; plus linear word counter.
    logic [BIT_W-1:0]    r_bit;
    logic [COL_W-1:0]    r_col;
    logic [Y_W-1:0]      r_y;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic [WORD_W-1:0]   r_shift;

    logic                w_clear_start;
    logic                w_fill_wr;
    logic [ADDR_W-1:0]   w_fill_addr;
    logic                w_fill_val;

    logic                w_accept;
    logic [BIT_W-1:0]    w_bit;
    logic [COL_W-1:0]    w_col;
    logic [Y_W-1:0]      w_y;
    logic [ADDR_W-1:0]   w_word;
    logic [WORD_W-1:0]   w_shift;
    logic                w_word_done;
    logic                w_row_end;
    logic                w_frame_end;

`ifdef VRAM_WRITER_CLEAR_EN
    logic                r_busy;
    logic                r_clear_val;
    logic [ADDR_W-1:0]   r_fill_addr;
`else
    logic                w_unused_clear;
    assign w_unused_clear = bus.ClearReq ^ bus.ClearVal;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and clear-fill control.
    always_comb begin
        w_next_state  = r_state;
        w_clear_start = 1'b0;
        w_fill_wr     = 1'b0;
        w_fill_addr   = '0;
        w_fill_val    = 1'b0;
        case (r_state)
            ST_RUN: begin
`ifdef VRAM_WRITER_CLEAR_EN
                // The first fill write goes out together with the transition,
                // so the clear occupies exactly N_WORDS output cycles.
                if (bus.ClearReq) begin
                    w_clear_start = 1'b1;
                    w_fill_wr     = 1'b1;
                    w_fill_val    = bus.ClearVal;
                    w_next_state  = (N_WORDS > 1) ? ST_CLEAR : ST_RUN;
                end
`endif
            end
            ST_CLEAR: begin
`ifdef VRAM_WRITER_CLEAR_EN
                w_fill_wr   = 1'b1;
                w_fill_addr = r_fill_addr;
                w_fill_val  = r_clear_val;
                if (r_fill_addr == LAST_WORD) begin
                    w_next_state = ST_RUN;
                end
`else
                w_next_state = ST_RUN;
`endif
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Pixel placement: a SOF pixel restarts at (0,0) and drops any partial word.
    always_comb begin
        w_accept = bus.PixValid && r_pix_ready;
        w_bit    = bus.PixSof ? '0 : r_bit;
        w_col    = bus.PixSof ? '0 : r_col;
        w_y      = bus.PixSof ? '0 : r_y;
        w_word   = bus.PixSof ? '0 : r_word_cnt;
        w_shift  = bus.PixSof ? '0 : r_shift;
        w_shift[w_bit] = bus.PixData;
        w_row_end   = (w_col == LAST_COL);
        w_frame_end = w_row_end && (w_y == LAST_Y);
        w_word_done = w_accept && !w_clear_start && (w_bit == LAST_BIT);
    end

    // Pixel counters and shift register; a clear start resets the raster position.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_bit      <= '0;
            r_col      <= '0;
            r_y        <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
        end else if (w_clear_start) begin
            r_bit      <= '0;
            r_col      <= '0;
            r_y        <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
        end else if (w_accept) begin
            r_shift <= w_shift;
            if (w_bit == LAST_BIT) begin
                r_bit      <= '0;
                r_word_cnt <= w_frame_end ? '0 : (w_word + ADDR_W'(1));
                if (w_row_end) begin
                    r_col <= '0;
                    r_y   <= (w_y == LAST_Y) ? '0 : (w_y + Y_W'(1));
                end else begin
                    r_col <= w_col + COL_W'(1);
                    r_y   <= w_y;
                end
            end else begin
                r_bit      <= w_bit + BIT_W'(1);
                r_col      <= w_col;
                r_y        <= w_y;
                r_word_cnt <= w_word;
            end
        end
    end

    // Registered write port, handshake ready and frame pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pix_ready  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // Ready stays low through the last fill write so it never overlaps Busy.
            r_pix_ready  <= (w_next_state == ST_RUN) && !w_fill_wr;
            r_wr_en      <= w_fill_wr || w_word_done;
            r_frame_done <= w_word_done && w_frame_end;
            if (w_fill_wr) begin
                r_wr_addr <= w_fill_addr;
                r_wr_data <= {WORD_W{w_fill_val}};
            end else if (w_word_done) begin
                r_wr_addr <= w_word;
                r_wr_data <= w_shift;
            end
        end
    end

`ifdef VRAM_WRITER_CLEAR_EN
    // Clear engine: fill address counter, latched fill value and Busy flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_busy      <= 1'b0;
            r_clear_val <= 1'b0;
            r_fill_addr <= '0;
        end else begin
            r_busy <= w_fill_wr;
            if (w_clear_start) begin
                r_clear_val <= bus.ClearVal;
            end
            if (w_fill_wr) begin
                r_fill_addr <= w_fill_addr + ADDR_W'(1);
            end
        end
    end

    assign bus.Busy = r_busy;
`else
    assign bus.Busy = 1'b0;
`endif

    assign bus.PixReady  = r_pix_ready;
    assign bus.WrEn      = r_wr_en;
    assign bus.WrAddr    = r_wr_addr;
    assign bus.WrData    = r_wr_data;
    assign bus.FrameDone = r_frame_done;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer on a small 16x4 frame (8 words of 8 pixels).
module tb_vram_writer;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int W  = 8;
    localparam int AW = 8;
    localparam int NW = H * V / W;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    vram_writer_if #(.WORD_W(W), .ADDR_W(AW)) bus ();

    vram_writer #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .WORD_W  (W),
        .ADDR_W  (AW)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] mon_addr[$];
    logic [W-1:0]  mon_data[$];
    logic          mon_fd[$];
    int            fd_cnt   = 0;
    int            busy_cnt = 0;

    // Write-port monitor sampled on the falling edge.
    always @(negedge Clk) begin
        if (bus.WrEn) begin
            mon_addr.push_back(bus.WrAddr);
            mon_data.push_back(bus.WrData);
            mon_fd.push_back(bus.FrameDone);
        end
        if (bus.FrameDone) fd_cnt++;
        if (bus.Busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Offer one pixel, entered and left at 1 time unit after a rising edge.
    task automatic send_pix(input logic d, input logic sof);
        int   t;
        logic rdy;
        bus.PixValid = 1'b1;
        bus.PixData  = d;
        bus.PixSof   = sof;
        t = 0;
        do begin
            @(negedge Clk);
            rdy = bus.PixReady;
            @(posedge Clk);
            #1;
            t++;
        end while (!rdy && t < 50);
        if (!rdy) check("accept_timeout", rdy, 1'b1);
        bus.PixValid = 1'b0;
        bus.PixSof   = 1'b0;
    endtask

    // seq[0] is the first pixel sent.
    task automatic send_word(input logic [0:7] seq, input logic sof);
        for (int i = 0; i < 8; i++) send_pix(seq[i], sof && (i == 0));
    endtask

    task automatic check_one_write(input string tag, input int mb,
                                   input logic [AW-1:0] a, input logic [W-1:0] d);
        check({tag, "_count"}, mon_addr.size(), mb + 1);
        if (mon_addr.size() > mb) begin
            check({tag, "_addr"}, mon_addr[mb], a);
            check({tag, "_data"}, mon_data[mb], d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    logic pix[0:71];
    logic [W-1:0] exp_w;
    int mb;
    int fd0;
    int busy_hi, rdy_lo, wr_ok;

    initial begin
        bus.PixValid = 1'b0;
        bus.PixData  = 1'b0;
        bus.PixSof   = 1'b0;
        bus.ClearReq = 1'b0;
        bus.ClearVal = 1'b0;

        // Reset values
        #3;
        check("rst_ready", bus.PixReady, 1'b0);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_wren", bus.WrEn, 1'b0);
        check("rst_addr", bus.WrAddr, 8'h00);
        check("rst_data", bus.WrData, 8'h00);
        check("rst_fd", bus.FrameDone, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("ready_before_edge", bus.PixReady, 1'b0);
        @(posedge Clk);
        #1;
        check("ready_after_edge", bus.PixReady, 1'b1);

        // Single word, SOF on a pixel already at (0,0)
        mb = mon_addr.size();
        send_word(8'b1011_0001, 1'b1);
        check("single_wren_latency", bus.WrEn, 1'b1);
        check("single_addr_now", bus.WrAddr, 8'h00);
        idle(1);
        check("single_wren_pulse", bus.WrEn, 1'b0);
        idle(2);
        check_one_write("single", mb, 8'h00, 8'h8D);

        // Full frame with random gaps, then 8 more pixels wrap to address 0
        for (int i = 0; i < 64; i++) pix[i] = 1'($urandom_range(0, 1));
        for (int i = 64; i < 72; i++) pix[i] = (i < 67);
        mb  = mon_addr.size();
        fd0 = fd_cnt;
        for (int i = 0; i < 72; i++) begin
            idle($urandom_range(0, 2));
            send_pix(pix[i], i == 0);
        end
        idle(3);
        check("frame_count", mon_addr.size(), mb + NW + 1);
        check("frame_fd_total", fd_cnt - fd0, 1);
        for (int w = 0; w <= NW; w++) begin
            for (int b = 0; b < 8; b++) exp_w[b] = pix[w * 8 + b];
            if (mon_addr.size() > mb + w) begin
                check($sformatf("frame_addr%0d", w), mon_addr[mb + w], w % NW);
                check($sformatf("frame_data%0d", w), mon_data[mb + w], exp_w);
                check($sformatf("frame_fd%0d", w), mon_fd[mb + w], w == NW - 1);
            end
        end
        if (mon_addr.size() > mb + NW) check("wrap_data", mon_data[mb + NW], 8'h07);

        // Mid-word SOF discards the partial word
        mb = mon_addr.size();
        send_pix(1'b1, 1'b0);
        send_pix(1'b1, 1'b0);
        send_pix(1'b1, 1'b0);
        idle(2);
        check("midsof_no_partial", mon_addr.size(), mb);
        send_word(8'b0110_1010, 1'b1);
        idle(2);
        check_one_write("midsof", mb, 8'h00, 8'h56);

        // Asynchronous reset while a write is on the port
        send_word(8'b1111_1111, 1'b0);
        check("rst_pre_wren", bus.WrEn, 1'b1);
        #1;
        Rst_n = 1'b0;
        #1;
        check("rst_mid_wren", bus.WrEn, 1'b0);
        check("rst_mid_addr", bus.WrAddr, 8'h00);
        check("rst_mid_data", bus.WrData, 8'h00);
        check("rst_mid_ready", bus.PixReady, 1'b0);
        check("rst_mid_fd", bus.FrameDone, 1'b0);
        mb = mon_addr.size();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_rel_ready", bus.PixReady, 1'b1);
        idle(3);
        check("rst_no_stale", mon_addr.size(), mb);
        send_word(8'b0101_0101, 1'b0);
        idle(2);
        check_one_write("rst_restart", mb, 8'h00, 8'hAA);

`ifdef VRAM_WRITER_CLEAR_EN
        // Clear while PixValid is held high, with a partial word pending
        send_pix(1'b1, 1'b0);
        send_pix(1'b1, 1'b0);
        send_pix(1'b1, 1'b0);
        fd0 = fd_cnt;
        bus.PixValid = 1'b1;
        bus.PixData  = 1'b0;
        bus.ClearReq = 1'b1;
        bus.ClearVal = 1'b1;
        @(posedge Clk);
        #1;
        bus.ClearReq = 1'b0;
        bus.ClearVal = 1'b0;
        busy_hi = 0;
        rdy_lo  = 0;
        wr_ok   = 0;
        for (int i = 0; i < NW; i++) begin
            @(negedge Clk);
            bus.ClearReq = (i == 3);
            if (bus.Busy) busy_hi++;
            if (!bus.PixReady) rdy_lo++;
            if (bus.WrEn && bus.WrAddr == AW'(i) && bus.WrData == 8'hFF) wr_ok++;
        end
        @(negedge Clk);
        bus.ClearReq = 1'b0;
        check("clear_end_busy", bus.Busy, 1'b0);
        check("clear_end_ready", bus.PixReady, 1'b1);
        check("clear_end_wren", bus.WrEn, 1'b0);
        bus.PixValid = 1'b0;
        check("clear_busy_cycles", busy_hi, NW);
        check("clear_ready_low_cycles", rdy_lo, NW);
        check("clear_writes_ff", wr_ok, NW);
        check("clear_no_fd", fd_cnt - fd0, 0);
        @(posedge Clk);
        #1;
        mb = mon_addr.size();
        send_word(8'b1100_1100, 1'b0);
        idle(2);
        check_one_write("clear_restart", mb, 8'h00, 8'h33);
`else
        // ClearReq pulsed mid-word has no effect on the stream
        mb = mon_addr.size();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bus.ClearReq = 1'b1;
                bus.ClearVal = 1'b1;
            end
            send_pix((8'hB9 >> i) & 8'h01 ? 1'b1 : 1'b0, 1'b0);
            bus.ClearReq = 1'b0;
            bus.ClearVal = 1'b0;
        end
        idle(4);
        check("noclear_busy_cycles", busy_cnt, 0);
        check_one_write("noclear", mb, 8'h01, 8'hB9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
